// File: rtl/tournament_chooser_table.sv
`default_nettype none
// ============================================================================
// Module      : tournament_chooser_table
// Description : Tournament chooser table of saturating choice counters that
//               select predictor A (local) or predictor B (global) per branch.
//               PC-indexed, optionally XOR-hashed with a global history
//               register. Includes a DEPTH-cycle table clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tournament_chooser_table #(
    parameter int IDX_WIDTH = 6,
    parameter int CNT_WIDTH = 2,
    parameter int HASH_MODE = 1,
    parameter int INIT_CNT  = 2**(CNT_WIDTH-1) - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lookup_valid,
    input  logic [31:0]          lookup_pc,
    output logic                 pred_valid,
    output logic                 pred_sel_b,
    output logic [CNT_WIDTH-1:0] pred_cnt,
    output logic [IDX_WIDTH-1:0] pred_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic [IDX_WIDTH-1:0] upd_ghr,
    input  logic                 upd_a_correct,
    input  logic                 upd_b_correct,
    input  logic                 upd_taken,
    input  logic                 clear,
    output logic                 ready
);

    localparam int                   c_depth    = 2**IDX_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_init_cnt = CNT_WIDTH'(INIT_CNT);
    localparam logic [CNT_WIDTH-1:0] c_cmax     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;
    localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(c_depth - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_table [c_depth];
    logic [IDX_WIDTH-1:0]   r_ghr;
    logic [IDX_WIDTH-1:0]   r_ptr;

    logic [IDX_WIDTH-1:0]   w_lk_idx;
    logic [IDX_WIDTH-1:0]   w_up_idx;
    logic                   w_upd_en;
    logic [CNT_WIDTH-1:0]   w_upd_cur;
    logic [CNT_WIDTH-1:0]   w_upd_cnt;
    logic [CNT_WIDTH-1:0]   w_lk_cnt;
    logic                   w_unused_bits;

    // PC bits outside the index field (and history when unhashed) are don't-care
    assign w_unused_bits = ^{lookup_pc[31:IDX_WIDTH+2], lookup_pc[1:0],
                             upd_pc[31:IDX_WIDTH+2], upd_pc[1:0], upd_ghr};

    generate
        if (HASH_MODE != 0) begin : g_hash
            // Lookup hashes with live history, update with the prediction-time snapshot
            assign w_lk_idx = lookup_pc[IDX_WIDTH+1:2] ^ r_ghr;
            assign w_up_idx = upd_pc[IDX_WIDTH+1:2] ^ upd_ghr;
        end else begin : g_nohash
            assign w_lk_idx = lookup_pc[IDX_WIDTH+1:2];
            assign w_up_idx = upd_pc[IDX_WIDTH+1:2];
        end
    endgenerate

    // A clear pulse takes precedence over an update in the same cycle
    assign w_upd_en  = upd_valid && (r_state == ST_IDLE) && !clear;
    assign w_upd_cur = r_table[w_up_idx];
    assign ready     = (r_state == ST_IDLE);

    // Saturating counter step: toward B when only B was right, toward A when only A was
    always_comb begin
        w_upd_cnt = w_upd_cur;
        if (upd_b_correct && !upd_a_correct && (w_upd_cur != c_cmax))
            w_upd_cnt = w_upd_cur + CNT_WIDTH'(1);
        else if (upd_a_correct && !upd_b_correct && (w_upd_cur != c_cnt_zero))
            w_upd_cnt = w_upd_cur - CNT_WIDTH'(1);
    end

    // Lookup value with write-through forwarding; a sweeping table reads as INIT
    always_comb begin
        w_lk_cnt = r_table[w_lk_idx];
        if (r_state == ST_CLEAR)
            w_lk_cnt = c_init_cnt;
        else if (w_upd_en && (w_up_idx == w_lk_idx))
            w_lk_cnt = w_upd_cnt;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state: a clear pulse (re)starts the sweep, which ends after the last entry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (clear) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (!clear && (r_ptr == c_last_idx)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Sweep pointer and global history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_ghr <= '0;
        end else begin
            if (clear)                  r_ptr <= '0;
            else if (r_state == ST_CLEAR) r_ptr <= r_ptr + IDX_WIDTH'(1);
            if (clear)                  r_ghr <= '0;
            else if (w_upd_en)          r_ghr <= {r_ghr[IDX_WIDTH-2:0], upd_taken};
        end
    end

    // Counter table: sweep writes INIT one entry per cycle, otherwise apply updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_depth; i++) r_table[i] <= c_init_cnt;
        end else if (r_state == ST_CLEAR) begin
            r_table[r_ptr] <= c_init_cnt;
        end else if (w_upd_en) begin
            r_table[w_up_idx] <= w_upd_cnt;
        end
    end

    // Registered prediction outputs, one cycle after the lookup request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_sel_b <= 1'b0;
            pred_cnt   <= '0;
            pred_ghr   <= '0;
        end else begin
            pred_valid <= lookup_valid;
            if (lookup_valid) begin
                pred_cnt   <= w_lk_cnt;
                pred_sel_b <= w_lk_cnt[CNT_WIDTH-1];
                pred_ghr   <= r_ghr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tournament_chooser_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_tournament_chooser_table
// Description : Directed self-checking bench for tournament_chooser_table
//               (IDX_WIDTH=6, CNT_WIDTH=2, HASH_MODE=1, INIT_CNT=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tournament_chooser_table;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_valid;
    logic        pred_sel_b;
    logic [1:0]  pred_cnt;
    logic [5:0]  pred_ghr;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [5:0]  upd_ghr = '0;
    logic        upd_a_correct = 1'b0;
    logic        upd_b_correct = 1'b0;
    logic        upd_taken = 1'b0;
    logic        clear = 1'b0;
    logic        ready;

    int total = 0;
    int bad   = 0;

    tournament_chooser_table #(
        .IDX_WIDTH(6), .CNT_WIDTH(2), .HASH_MODE(1), .INIT_CNT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_sel_b(pred_sel_b),
        .pred_cnt(pred_cnt), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_a_correct(upd_a_correct), .upd_b_correct(upd_b_correct),
        .upd_taken(upd_taken), .clear(clear), .ready(ready)
    );

    always #5 clk = ~clk;

    // Advance one cycle; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic lookup(input logic [31:0] pc);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        tick();
        lookup_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic [5:0] g,
                          input logic a, input logic b, input logic t);
        upd_valid = 1'b1; upd_pc = pc; upd_ghr = g;
        upd_a_correct = a; upd_b_correct = b; upd_taken = t;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if (pred_valid !== 1'b0 || pred_cnt !== 2'b00 || pred_sel_b !== 1'b0 ||
            pred_ghr !== 6'd0 || ready !== 1'b1) begin
            $display("FAIL reset: valid=%b cnt=%b sel=%b ghr=%b ready=%b, want 0 00 0 000000 1",
                     pred_valid, pred_cnt, pred_sel_b, pred_ghr, ready);
            bad++;
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lookup_basic();
        do_reset();
        lookup(32'h40);
        total++;
        if (pred_valid !== 1'b1 || pred_cnt !== 2'b01 || pred_sel_b !== 1'b0 || pred_ghr !== 6'd0) begin
            $display("FAIL lookup_basic: valid=%b cnt=%b sel=%b ghr=%b, want 1 01 0 000000",
                     pred_valid, pred_cnt, pred_sel_b, pred_ghr);
            bad++;
        end
        tick();
        total++;
        if (pred_valid !== 1'b0) begin
            $display("FAIL lookup_valid_drop: valid=%b, want 0", pred_valid);
            bad++;
        end
    endtask

    task automatic test_sat_b();
        logic [1:0] exp_cnt [3];
        exp_cnt[0] = 2'b10; exp_cnt[1] = 2'b11; exp_cnt[2] = 2'b11;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            update(32'h40, 6'd0, 1'b0, 1'b1, 1'b0);
            lookup(32'h40);
            total++;
            if (pred_cnt !== exp_cnt[i]) begin
                $display("FAIL sat_b step %0d: cnt=%b, want %b", i, pred_cnt, exp_cnt[i]);
                bad++;
            end
        end
        total++;
        if (pred_sel_b !== 1'b1) begin
            $display("FAIL sat_b sel: sel=%b, want 1", pred_sel_b);
            bad++;
        end
    endtask

    task automatic test_sat_a_and_tie();
        do_reset();
        for (int i = 0; i < 4; i++) update(32'h80, 6'd0, 1'b1, 1'b0, 1'b0);
        lookup(32'h80);
        total++;
        if (pred_cnt !== 2'b00 || pred_sel_b !== 1'b0) begin
            $display("FAIL sat_a: cnt=%b sel=%b, want 00 0", pred_cnt, pred_sel_b);
            bad++;
        end
        update(32'h80, 6'd0, 1'b1, 1'b1, 1'b0);
        update(32'h80, 6'd0, 1'b0, 1'b0, 1'b0);
        lookup(32'h80);
        total++;
        if (pred_cnt !== 2'b00) begin
            $display("FAIL tie: cnt=%b, want 00", pred_cnt);
            bad++;
        end
    endtask

    task automatic test_forward();
        do_reset();
        lookup_valid = 1'b1; lookup_pc = 32'h100;
        update(32'h100, 6'd0, 1'b0, 1'b1, 1'b0);
        lookup_valid = 1'b0;
        total++;
        if (pred_cnt !== 2'b10 || pred_sel_b !== 1'b1) begin
            $display("FAIL forward: cnt=%b sel=%b, want 10 1", pred_cnt, pred_sel_b);
            bad++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        upd_valid = 1'b1; upd_pc = 32'hC0; upd_ghr = 6'd0;
        upd_a_correct = 1'b0; upd_b_correct = 1'b1; upd_taken = 1'b0;
        tick();
        tick();
        upd_valid = 1'b0;
        lookup(32'hC0);
        total++;
        if (pred_cnt !== 2'b11) begin
            $display("FAIL back_to_back: cnt=%b, want 11", pred_cnt);
            bad++;
        end
    endtask

    task automatic test_ghr_hash();
        do_reset();
        // entry 010110 -> 10 while history stays zero
        update(32'h40, 6'b000110, 1'b0, 1'b1, 1'b0);
        update(32'h200, 6'd0, 1'b1, 1'b1, 1'b1);
        update(32'h200, 6'd0, 1'b1, 1'b1, 1'b1);
        update(32'h200, 6'd0, 1'b1, 1'b1, 1'b0);
        lookup(32'h40);
        total++;
        if (pred_ghr !== 6'b000110 || pred_cnt !== 2'b10 || pred_sel_b !== 1'b1) begin
            $display("FAIL ghr_hash: ghr=%b cnt=%b sel=%b, want 000110 10 1",
                     pred_ghr, pred_cnt, pred_sel_b);
            bad++;
        end
    endtask

    task automatic test_clear();
        int n;
        int errs;
        do_reset();
        update(32'h40, 6'd0, 1'b0, 1'b1, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (ready !== 1'b0) begin
            $display("FAIL clear_start: ready=%b, want 0", ready);
            bad++;
        end
        n = 0;
        errs = 0;
        while (ready !== 1'b1 && n < 200) begin
            lookup_valid = 1'b1; lookup_pc = 32'h40;
            update(32'h80, 6'd0, 1'b0, 1'b1, 1'b1);
            n++;
            if (pred_valid !== 1'b1 || pred_cnt !== 2'b01 || pred_sel_b !== 1'b0) errs++;
        end
        lookup_valid = 1'b0;
        total++;
        if (n !== 64) begin
            $display("FAIL clear_len: ready-low cycles=%0d, want 64", n);
            bad++;
        end
        total++;
        if (errs !== 0) begin
            $display("FAIL clear_lookup: bad lookups during sweep=%0d, want 0", errs);
            bad++;
        end
        errs = 0;
        for (int i = 0; i < 64; i++) begin
            lookup(32'(i) << 2);
            if (pred_cnt !== 2'b01 || pred_ghr !== 6'd0) errs++;
        end
        total++;
        if (errs !== 0) begin
            $display("FAIL clear_entries: bad entries=%0d, want 0", errs);
            bad++;
        end
    endtask

    task automatic test_clear_restart();
        int n;
        do_reset();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (9) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (n !== 64) begin
            $display("FAIL clear_restart: ready-low cycles=%0d, want 64", n);
            bad++;
        end
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        update(32'h40, 6'd0, 1'b0, 1'b1, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (ready !== 1'b1 || pred_valid !== 1'b0) begin
            $display("FAIL reset_mid_clear: ready=%b valid=%b, want 1 0", ready, pred_valid);
            bad++;
        end
        tick();
        rst_n = 1'b1;
        tick();
        lookup(32'h40);
        total++;
        if (pred_cnt !== 2'b01 || ready !== 1'b1) begin
            $display("FAIL reset_mid_clear_after: cnt=%b ready=%b, want 01 1", pred_cnt, ready);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_lookup_basic();
        test_sat_b();
        test_sat_a_and_tie();
        test_forward();
        test_back_to_back();
        test_ghr_hash();
        test_clear();
        test_clear_restart();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tournament_chooser_table.md
# tournament_chooser_table

Parametrised tournament chooser for the fetch stage. It holds a table of saturating choice counters that select between predictor A (local) and predictor B (global) per branch. The table is indexed by PC, optionally hashed with a global history register (GHR). It is updated at branch resolution with the correctness of both component predictors, and supports a multi-cycle table clear sequenced by a small FSM.

## Interface
- IDX_WIDTH, 6: table index width; DEPTH = 2^IDX_WIDTH entries.
- CNT_WIDTH, 2: choice counter width (≥2); CMAX = 2^CNT_WIDTH−1.
- HASH_MODE, 1: 0 = index is pc[IDX_WIDTH+1:2]; 1 = index is pc[IDX_WIDTH+1:2] XOR ghr.
- INIT_CNT, 2^(CNT_WIDTH−1)−1: reset/clear counter value (weakly prefer A).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  32  fetch PC.
- pred_valid  out  1  registered; lookup_valid delayed one cycle.
- pred_sel_b  out  1  registered; MSB of the looked-up counter (1 = use B).
- pred_cnt  out  CNT_WIDTH  registered looked-up counter value.
- pred_ghr  out  IDX_WIDTH  registered GHR snapshot used for the lookup; the pipeline carries it to upd_ghr.
- upd_valid  in  1  resolved-branch update.
- upd_pc  in  32  PC of the resolved branch.
- upd_ghr  in  IDX_WIDTH  GHR snapshot from the prediction.
- upd_a_correct  in  1  predictor A was correct.
- upd_b_correct  in  1  predictor B was correct.
- upd_taken  in  1  actual outcome; shifted into the GHR.
- clear  in  1  single-cycle pulse; starts a table clear.
- ready  out  1  high when in IDLE; low while clearing.

## Operation
- Counter rule, applied on upd_valid in IDLE:
  - a_correct == b_correct: counter unchanged.
  - a_correct only: decrement, saturating at 0.
  - b_correct only: increment, saturating at CMAX.
- Lookup index uses the current GHR register value (HASH_MODE=1). Update index uses upd_ghr. In HASH_MODE=0 both ignore history.
- GHR: on upd_valid in IDLE, ghr <= {ghr[IDX_WIDTH−2:0], upd_taken}.
- FSM states:
  - IDLE: lookups and updates are serviced.
  - CLEAR: a sweep pointer walks 0..DEPTH−1 and writes INIT_CNT to one entry per cycle.
- Transitions:
  - IDLE→CLEAR on clear. The GHR is zeroed and the pointer set to 0 at that edge.
  - CLEAR→IDLE after the DEPTH−1 entry is written.
  - clear asserted during CLEAR restarts the sweep with the pointer at 0.
- Behaviour during CLEAR:
  - upd_valid is dropped, with no table or GHR change.
  - Lookups still complete: pred_valid=1, pred_cnt=INIT_CNT, pred_sel_b=INIT_CNT[MSB].
- Reset values: all counters = INIT_CNT, GHR=0, state IDLE, pointer 0, pred_valid=0, pred_sel_b=0, pred_cnt=0, pred_ghr=0, ready=1.
- Reset asserted mid-clear aborts the sweep; the reset values above apply immediately.

## Timing
- Lookup latency is 1 cycle: a request in cycle t produces pred_* valid in cycle t+1.
- An update in cycle t is written to the table at the end-of-t edge.
- Same-cycle read/write to the same index: the lookup returns the post-update counter (write-through forwarding). The GHR used for that lookup is the pre-update value.
- Back-to-back updates to the same index in consecutive cycles accumulate; no update is lost.
- Clear sequence:
  - clear in cycle t: ready=0 from t+1 through t+DEPTH.
  - ready=1 at t+DEPTH+1.
  - The sweep takes exactly DEPTH cycles.
- There are no stalls and no backpressure on lookup or update.

## Test plan
- Reset then lookup, pc=0x40, HASH_MODE=1, defaults -> next cycle pred_valid=1, pred_cnt=01, pred_sel_b=0, pred_ghr=0.
- Three updates to pc=0x40 (upd_ghr=0, a=0, b=1) -> counter 01→10→11→11 (saturates); lookup then gives pred_sel_b=1.
- Saturation toward A, then the tie case:
  - Four updates to pc=0x80 with a=1, b=0 -> counter saturates at 00.
  - Then a=1, b=1 and a=0, b=0 -> counter stays 00.
- Same-cycle forwarding: lookup and update (a=0, b=1) both hitting the index of pc=0x100 with counter 01 -> pred_cnt=10 next cycle.
- GHR hashing: updates with upd_taken=1,1,0 -> GHR=000110. Lookup pc=0x40 then uses index 010000^000110 = 010110, and pred_ghr=000110.
- Clear sequence:
  - Clear with the counters modified -> ready low for 64 cycles; updates during the sweep are ignored; lookups during the sweep return 01.
  - After the sweep, all entries read 01 and GHR=0.
  - Asserting rst_n=0 mid-sweep -> ready=1 and state IDLE immediately.
